tank_level_sensor: RTL and testbench

TANK_LEVEL_SENSOR -- requirements
Module: tank_level_sensor

---
 rtl/tank_level_sensor.sv | 98 +++++++++
 tb/tb_tank_level_sensor.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tank_level_sensor.sv
// Tank plant model: prescaled tick integrates pump fill and demand drain into a clamped 8-bit level.
// Level updates on the tick edge; I/S one clock later; sticky faults; no backpressure (free-running).
module tank_level_sensor #(
   parameter int TICK_DIV   = 4,
   parameter int FILL       = 2,
   parameter int DRAIN      = 3,
   parameter int LOW_TH     = 64,
   parameter int HIGH_TH    = 192,
   parameter int LEVEL_INIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       P1,
   input  logic       P2,
   input  logic       demand,
   output logic       I,
   output logic       S,
   output logic [7:0] level,
   output logic       overflow,
   output logic       dry,
   output logic       alt_fault,
   output logic       ctrl_fault
);

   localparam int              CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);
   localparam logic [7:0]      LOW8    = 8'(LOW_TH);
   localparam logic [7:0]      HIGH8   = 8'(HIGH_TH);
   localparam logic [7:0]      INIT8   = 8'(LEVEL_INIT);
   localparam logic signed [10:0] FILL_S  = 11'(FILL);
   localparam logic signed [10:0] DRAIN_S = 11'(DRAIN);

   logic [CW-1:0]      cnt;
   logic               tick;
   logic [1:0]         pat;
   logic [1:0]         prev_pat;
   logic [1:0]         last_pump;
   logic [1:0]         npump;
   logic signed [10:0] raw;
   logic [7:0]         level_nxt;
   logic               episode;
   logic               run_s;
   logic               prev_run_s;

   always_comb begin
      tick      = (cnt == CNT_MAX);
      pat       = {P1, P2};
      npump     = {1'b0, P1} + {1'b0, P2};
      raw       = $signed({3'b000, level}) + FILL_S * $signed({9'd0, npump})
                  - (demand ? DRAIN_S : 11'sd0);
      level_nxt = raw[7:0];
      if (raw < 11'sd0)
         level_nxt = 8'd0;
      else if (raw > 11'sd255)
         level_nxt = 8'hff;
      // An episode starts only on the transition into a one-hot pattern.
      episode   = ((pat == 2'b10) || (pat == 2'b01)) && (pat != prev_pat);
      run_s     = (P1 | P2) & S;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         level      <= INIT8;
         I          <= (INIT8 >= LOW8);
         S          <= (INIT8 >= HIGH8);
         overflow   <= 1'b0;
         dry        <= 1'b0;
         alt_fault  <= 1'b0;
         ctrl_fault <= 1'b0;
         prev_pat   <= 2'b00;
         last_pump  <= 2'b00;
         prev_run_s <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + CW'(1);
         I   <= (level >= LOW8);
         S   <= (level >= HIGH8);
         if (tick) begin
            level    <= level_nxt;
            prev_pat <= pat;
            if (raw > 11'sd255)
               overflow <= 1'b1;
            if (raw < 11'sd0)
               dry <= 1'b1;
            // last_pump == 00 means no episode yet, which can never match a one-hot pattern.
            if (episode) begin
               if (last_pump == pat)
                  alt_fault <= 1'b1;
               last_pump <= pat;
            end
            prev_run_s <= run_s;
            if (run_s && prev_run_s)
               ctrl_fault <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tank_level_sensor.sv
// Directed bench for tank_level_sensor with default parameters (TICK_DIV=4, FILL=2, DRAIN=3).
module tb_tank_level_sensor;

   logic       clk = 1'b0;
   logic       rst;
   logic       P1;
   logic       P2;
   logic       demand;
   logic       I;
   logic       S;
   logic [7:0] level;
   logic       overflow;
   logic       dry;
   logic       alt_fault;
   logic       ctrl_fault;

   int n_checks = 0;
   int n_fail   = 0;

   tank_level_sensor dut (
      .clk(clk), .rst(rst), .P1(P1), .P2(P2), .demand(demand),
      .I(I), .S(S), .level(level), .overflow(overflow), .dry(dry),
      .alt_fault(alt_fault), .ctrl_fault(ctrl_fault)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; P1 = 1'b0; P2 = 1'b0; demand = 1'b0;
      step(2);
      chk8("rst_level", level, 8'd0);
      chk1("rst_I", I, 1'b0);
      chk1("rst_S", S, 1'b0);
      chk1("rst_overflow", overflow, 1'b0);
      chk1("rst_dry", dry, 1'b0);
      chk1("rst_alt", alt_fault, 1'b0);
      chk1("rst_ctrl", ctrl_fault, 1'b0);

      // Both pumps from empty: +4 per tick, tick k lands on clock 4k after release.
      rst = 1'b0; P1 = 1'b1; P2 = 1'b1;
      step(63);
      chk8("fill_t15_level", level, 8'd60);
      step(1);
      chk8("fill_t16_level", level, 8'd64);
      chk1("fill_t16_I_lag", I, 1'b0);
      step(1);
      chk1("fill_I_set", I, 1'b1);
      chk1("fill_S_clear", S, 1'b0);
      step(131);
      chk8("fill_t49_level", level, 8'd196);
      chk1("fill_t49_S", S, 1'b1);
      chk1("ctrl_one_tick", ctrl_fault, 1'b0);
      step(4);
      chk1("ctrl_two_ticks", ctrl_fault, 1'b1);
      chk8("fill_t50_level", level, 8'd200);
      step(52);
      chk8("fill_t63_level", level, 8'd252);
      chk1("no_overflow_252", overflow, 1'b0);
      step(4);
      chk8("clamp_255", level, 8'd255);
      chk1("overflow_set", overflow, 1'b1);
      chk1("clamp_S", S, 1'b1);

      // Drain only: 51 ticks of -3 gives 102; then one pump plus demand nets -1 per tick.
      P1 = 1'b0; P2 = 1'b0; demand = 1'b1;
      step(204);
      chk8("drain_102", level, 8'd102);
      P1 = 1'b1;
      step(8);
      chk8("net_100", level, 8'd100);
      chk1("overflow_sticky", overflow, 1'b1);
      chk1("ctrl_sticky", ctrl_fault, 1'b1);
      chk1("first_episode_ok", alt_fault, 1'b0);
      chk1("dry_clear", dry, 1'b0);

      // Reset two cycles into a prescale period; the pending tick must be discarded.
      step(2);
      rst = 1'b1;
      step(1);
      chk8("midrst_level", level, 8'd0);
      chk1("midrst_overflow", overflow, 1'b0);
      chk1("midrst_ctrl", ctrl_fault, 1'b0);
      rst = 1'b0; P1 = 1'b1; P2 = 1'b0; demand = 1'b0;
      step(3);
      chk8("midrst_no_early_tick", level, 8'd0);
      step(1);
      chk8("midrst_tick_at_4", level, 8'd2);

      // Level 2, drain 3 -> clamps at 0 and flags dry.
      P1 = 1'b0; demand = 1'b1;
      step(4);
      chk8("dry_level", level, 8'd0);
      chk1("dry_set", dry, 1'b1);
      step(1);
      chk1("dry_I", I, 1'b0);

      // Alternation: 10,01,00,10 is legal, then 00,10 repeats pump 1.
      rst = 1'b1; P1 = 1'b0; P2 = 1'b0; demand = 1'b0;
      step(2);
      chk1("rst2_dry", dry, 1'b0);
      rst = 1'b0; P1 = 1'b1;
      step(4);
      chk8("alt_t1_level", level, 8'd2);
      P1 = 1'b0; P2 = 1'b1;
      step(4);
      chk8("alt_t2_level", level, 8'd4);
      P1 = 1'b1; P2 = 1'b1; demand = 1'b1;
      step(2);
      P1 = 1'b0; P2 = 1'b0; demand = 1'b0;
      step(2);
      chk8("off_tick_ignored", level, 8'd4);
      P1 = 1'b1;
      step(4);
      chk8("alt_t4_level", level, 8'd6);
      chk1("alt_10_01_00_10", alt_fault, 1'b0);
      P1 = 1'b0;
      step(4);
      chk1("alt_after_00", alt_fault, 1'b0);
      P1 = 1'b1;
      step(4);
      chk8("alt_t6_level", level, 8'd8);
      chk1("alt_10_00_10", alt_fault, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
